flag_branch_unit: RTL
=====================

Name: flag_branch_unit

Overview:
- Sequential successor to the combinational control/branch decode: owns the N/Z/V flag register, resolves B/BR conditions, computes branch target, drives a multi-cycle pipeline flush, latches halt, and keeps saturating branch statistics.
- Sits at the decode/execute boundary of the five-stage pipeline; fetch consumes taken/target, the hazard logic consumes flush/halted.

Parameters:
- WIDTH, 16, PC/data width.
- FLUSH_DEPTH, 1, cycles flush is asserted per taken branch (legal range 1..7).
- ENABLE_FWD, 1, 1 = same-cycle flag writes are forwarded into condition evaluation.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  pipeline stall; freezes all state.
- flag_we  in  3  per-flag write enable {N,Z,V} from EX (already qualified by instruction valid).
- alu_flags  in  3  {N,Z,V} produced by the ALU this cycle.
- br_valid  in  1  branch instruction present in decode.
- br_reg  in  1  0 = B (PC-relative), 1 = BR (register).
- ccc  in  3  condition code.
- pc_plus2  in  WIDTH  address of next sequential instruction.
- imm9  in  9  signed word offset for B.
- rs_data  in  WIDTH  register target for BR.
- halt_in  in  1  HLT decoded.
- taken  out  1  branch taken this cycle.
- target  out  WIDTH  redirect address.
- flush  out  1  squash younger stages.
- halted  out  1  sticky halt.
- flags  out  3  registered {N,Z,V}.
- br_count  out  CNT_WIDTH  branches evaluated.
- taken_count  out  CNT_WIDTH  branches taken.

Behaviour:
- Reset (async): flags=000, state IDLE, flush counter 0, both counters 0, taken=0, flush=0, halted=0.
- Flag register: each bit loads alu_flags bit on rising edge when its flag_we bit=1, stall=0, state!=HALTED; other bits hold.
- Effective flags for evaluation: ENABLE_FWD=1 -> per bit, alu_flags where flag_we=1 else register; ENABLE_FWD=0 -> register only.
- Conditions: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
- taken (comb) = br_valid & cond & !stall & state==IDLE.
- target (comb) = br_reg ? rs_data : pc_plus2 + (sext(imm9)<<1), truncated mod 2^WIDTH (wraps); value don't-care when taken=0 but must not be X.
- FSM IDLE/FLUSH/HALTED:
  - IDLE: taken -> flush=1 same cycle; if FLUSH_DEPTH>1 go FLUSH with count=FLUSH_DEPTH-1. halt_in & !stall & !taken -> HALTED. Simultaneous taken and halt_in: branch wins (HLT is in the shadow).
  - FLUSH: flush=1; decrement count on !stall; at count reaching 1 with !stall return to IDLE next cycle. br_valid and halt_in ignored (squashed), not counted.
  - HALTED: halted=1, flush=0, taken=0; flag writes, counters, branches ignored; exit only by rst.
- Counters: on !stall & state==IDLE & br_valid, br_count++; taken_count++ additionally if taken; both saturate at all-ones.
- stall=1: no state, flag, counter change; flush output holds its current level.
- Reset mid-FLUSH or in HALTED: outputs drop immediately (async).

Decomposition:
- Shared package: ccc encodings (CC_NEQ..CC_UNCOND), opcode constants for B/BR/HLT, FSM state enum, flag bit indices.
- One sub-module: branch_cond_eval (combinational ccc + flags -> cond); FSM, flag register and counters stay in top.

Test Plan:
- Flag write + fwd: flag_we=010, alu_flags=010, br_valid=1, ccc=001, same cycle, ENABLE_FWD=1 -> taken=1; with ENABLE_FWD=0 and flags reset -> taken=0, flags=010 next cycle.
- B wrap: pc_plus2=16'hFFFE, imm9=9'h001, br_reg=0, ccc=111 -> target=16'h0000, taken=1, br_count=1, taken_count=1.
- Negative offset/BR: pc_plus2=16'h0040, imm9=9'h1FE -> target=16'h003C; br_reg=1, rs_data=16'h1234 -> target=16'h1234.
- Multi-cycle flush: FLUSH_DEPTH=3, taken at cycle t, stall=1 at t+1 -> flush high t..t+3; branch at t+2 not taken, not counted.
- Halt: halt_in=1 in IDLE -> halted=1 next cycle, subsequent flag_we=111 leaves flags unchanged; rst pulse mid-cycle -> halted=0 immediately.
- Saturation: CNT_WIDTH=4, 17 taken unconditional branches -> br_count=taken_count=4'hF.

Source files
------------

// File: rtl/flag_branch_unit_pkg.sv
// Shared encodings for the flag/branch unit: condition codes, opcodes,
// FSM states and flag bit positions.
package flag_branch_unit_pkg;

   typedef enum logic [2:0] {
      CC_NEQ    = 3'b000,
      CC_EQ     = 3'b001,
      CC_GT     = 3'b010,
      CC_LT     = 3'b011,
      CC_GTE    = 3'b100,
      CC_LTE    = 3'b101,
      CC_OVF    = 3'b110,
      CC_UNCOND = 3'b111
   } cc_e;

   localparam logic [3:0] OP_B   = 4'hC;
   localparam logic [3:0] OP_BR  = 4'hD;
   localparam logic [3:0] OP_HLT = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/flag_branch_unit_cond.sv
// Combinational branch condition evaluation from condition code and {N,Z,V}.
module branch_cond_eval
   import flag_branch_unit_pkg::*;
(
   input  logic [2:0] ccc,
   input  logic [2:0] flags,
   output logic       cond
);

   logic w_n;
   logic w_z;
   logic w_v;

   assign w_n = flags[FLAG_N];
   assign w_z = flags[FLAG_Z];
   assign w_v = flags[FLAG_V];

   always_comb begin
      cond = 1'b0;
      case (cc_e'(ccc))
         CC_NEQ:    cond = ~w_z;
         CC_EQ:     cond = w_z;
         CC_GT:     cond = ~w_z & ~w_n;
         CC_LT:     cond = w_n;
         CC_GTE:    cond = w_z | (~w_z & ~w_n);
         CC_LTE:    cond = w_n | w_z;
         CC_OVF:    cond = w_v;
         CC_UNCOND: cond = 1'b1;
         default:   cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_branch_unit.sv
// Flag register, branch resolution/target, flush/halt FSM and saturating
// branch statistics at the decode/execute boundary.
module flag_branch_unit
   import flag_branch_unit_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int FLUSH_DEPTH = 1,
   parameter int ENABLE_FWD  = 1,
   parameter int CNT_WIDTH   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic [2:0]           flag_we,
   input  logic [2:0]           alu_flags,
   input  logic                 br_valid,
   input  logic                 br_reg,
   input  logic [2:0]           ccc,
   input  logic [WIDTH-1:0]     pc_plus2,
   input  logic [8:0]           imm9,
   input  logic [WIDTH-1:0]     rs_data,
   input  logic                 halt_in,
   output logic                 taken,
   output logic [WIDTH-1:0]     target,
   output logic                 flush,
   output logic                 halted,
   output logic [2:0]           flags,
   output logic [CNT_WIDTH-1:0] br_count,
   output logic [CNT_WIDTH-1:0] taken_count
);

   localparam logic [2:0] FD_M1 = 3'(FLUSH_DEPTH - 1);

   state_e               r_state;
   state_e               w_state_nxt;
   logic [2:0]           r_flush_cnt;
   logic [2:0]           w_flush_cnt_nxt;
   logic [2:0]           r_flags;
   logic [2:0]           w_eff_flags;
   logic                 w_cond;
   logic                 w_taken;
   logic                 w_flush;
   logic                 w_cnt_en;
   logic [WIDTH-1:0]     w_off;
   logic [CNT_WIDTH-1:0] r_br_count;
   logic [CNT_WIDTH-1:0] r_taken_count;

   assign w_eff_flags = (ENABLE_FWD != 0) ? ((alu_flags & flag_we) | (r_flags & ~flag_we))
                                          : r_flags;

   branch_cond_eval u_cond (
      .ccc   (ccc),
      .flags (w_eff_flags),
      .cond  (w_cond)
   );

   assign w_taken = br_valid & w_cond & ~stall & (r_state == ST_IDLE);

   // Word offset: sign-extend imm9 and scale by 2; the add wraps mod 2^WIDTH.
   assign w_off  = {{(WIDTH-10){imm9[8]}}, imm9, 1'b0};
   assign target = br_reg ? rs_data : (pc_plus2 + w_off);

   always_comb begin
      w_state_nxt     = r_state;
      w_flush_cnt_nxt = r_flush_cnt;
      w_flush         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_taken) begin
               w_flush = 1'b1;
               if (FLUSH_DEPTH > 1) begin
                  w_state_nxt     = ST_FLUSH;
                  w_flush_cnt_nxt = FD_M1;
               end
            end else if (halt_in & ~stall) begin
               w_state_nxt = ST_HALTED;
            end
         end
         ST_FLUSH: begin
            w_flush = 1'b1;
            if (~stall) begin
               if (r_flush_cnt <= 3'd1) begin
                  w_state_nxt     = ST_IDLE;
                  w_flush_cnt_nxt = '0;
               end else begin
                  w_flush_cnt_nxt = r_flush_cnt - 3'd1;
               end
            end
         end
         ST_HALTED: begin
            w_state_nxt = ST_HALTED;
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_flush_cnt_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_flush_cnt <= '0;
      end else if (~stall) begin
         r_state     <= w_state_nxt;
         r_flush_cnt <= w_flush_cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_flags <= '0;
      end else if (~stall && r_state != ST_HALTED) begin
         for (int unsigned i = 0; i < 3; i++) begin
            if (flag_we[i]) r_flags[i] <= alu_flags[i];
         end
      end
   end

   assign w_cnt_en = ~stall & (r_state == ST_IDLE) & br_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_br_count    <= '0;
         r_taken_count <= '0;
      end else if (w_cnt_en) begin
         if (r_br_count != '1) r_br_count <= r_br_count + 1'b1;
         if (w_taken && r_taken_count != '1) r_taken_count <= r_taken_count + 1'b1;
      end
   end

   assign taken       = w_taken;
   assign flush       = w_flush;
   assign halted      = (r_state == ST_HALTED);
   assign flags       = r_flags;
   assign br_count    = r_br_count;
   assign taken_count = r_taken_count;

endmodule
